// File: rtl/mem_io_router_if.sv
// mem_io_router_if: CPU-side request bus plus data-memory and peripheral buses of the router.
interface mem_io_router_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 32,
   parameter int N_IO   = 4
);
   logic                   cpu_req;
   logic                   cpu_we;
   logic [ADDR_W-1:0]      cpu_addr;
   logic [DATA_W-1:0]      cpu_wdata;
   logic [DATA_W/8-1:0]    cpu_be;
   logic                   cpu_ready;
   logic [DATA_W-1:0]      cpu_rdata;
   logic                   cpu_err;
   logic                   m_en;
   logic                   m_we;
   logic [ADDR_W-1:0]      m_addr;
   logic [DATA_W-1:0]      m_wdata;
   logic [DATA_W/8-1:0]    m_be;
   logic [DATA_W-1:0]      m_rdata;
   logic [N_IO-1:0]        io_sel;
   logic                   io_we;
   logic [ADDR_W-1:0]      io_addr;
   logic [DATA_W-1:0]      io_wdata;
   logic [DATA_W/8-1:0]    io_be;
   logic [N_IO*DATA_W-1:0] io_rdata;
   logic [N_IO-1:0]        io_ack;
   modport slave (
      input  cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_be, m_rdata, io_rdata, io_ack,
      output cpu_ready, cpu_rdata, cpu_err, m_en, m_we, m_addr, m_wdata, m_be,
             io_sel, io_we, io_addr, io_wdata, io_be
   );
   modport master (
      output cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_be, m_rdata, io_rdata, io_ack,
      input  cpu_ready, cpu_rdata, cpu_err, m_en, m_we, m_addr, m_wdata, m_be,
             io_sel, io_we, io_addr, io_wdata, io_be
   );
endinterface

// File: rtl/mem_io_router.sv
// mem_io_router: routes CPU loads/stores to data memory or one of N_IO acked peripheral channels.
module mem_io_router #(
   parameter int                DATA_W    = 32,
   parameter int                ADDR_W    = 32,
   parameter logic [ADDR_W-1:0] MEM_LOW   = 32'h0000_0000,
   parameter logic [ADDR_W-1:0] MEM_HIGH  = 32'h0000_FFFF,
   parameter int                N_IO      = 4,
   parameter logic [ADDR_W-1:0] IO_BASE   = 32'hFFFF_FC00,
   parameter int                IO_STRIDE = 16,
   parameter int                TIMEOUT   = 16
) (
   input logic             clk,
   input logic             rst,
   mem_io_router_if.slave  bus
);
   localparam int BW = DATA_W / 8;
   localparam int KW = N_IO > 1 ? $clog2(N_IO) : 1;
   localparam int SW = $clog2(IO_STRIDE);
   localparam int CW = $clog2(TIMEOUT);
   localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'(IO_STRIDE - 1);
   typedef enum logic [2:0] {IDLE, MEM, MEM_RD, IO_WAIT, RESP} state_t;
   state_t            state, nxt;
   logic [CW-1:0]     cnt;
   logic              we_q, err_q;
   logic [ADDR_W-1:0] addr_q, off_q;
   logic [DATA_W-1:0] wdata_q, rdata_q;
   logic [BW-1:0]     be_q;
   logic [KW-1:0]     k_q;
   logic [ADDR_W-1:0] off, kw;
   logic              mem_hit, io_hit, bad, ack, tmo;
   // Offset-based range test avoids a constant compare when MEM_LOW is zero.
   assign off     = bus.cpu_addr - IO_BASE;
   assign kw      = off >> SW;
   assign mem_hit = (bus.cpu_addr - MEM_LOW) <= (MEM_HIGH - MEM_LOW);
   assign io_hit  = bus.cpu_addr >= IO_BASE && kw < ADDR_W'(N_IO);
   assign bad     = bus.cpu_addr[1:0] != 2'b00 || !(mem_hit || io_hit);
   assign ack     = bus.io_ack[k_q];
   assign tmo     = cnt == CW'(TIMEOUT - 1);
   always_ff @(posedge clk or posedge rst)
      if (rst) state <= IDLE;
      else state <= nxt;
   always_comb begin
      nxt = state;
      case (state)
         IDLE:    if (bus.cpu_req) nxt = bad ? RESP : mem_hit ? MEM : IO_WAIT;
         MEM:     nxt = we_q ? RESP : MEM_RD;
         MEM_RD:  nxt = RESP;
         IO_WAIT: if (ack || tmo) nxt = RESP;
         default: nxt = IDLE;
      endcase
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         cnt     <= '0;
         we_q    <= 1'b0;
         err_q   <= 1'b0;
         addr_q  <= '0;
         off_q   <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         be_q    <= '0;
         k_q     <= '0;
      end else begin
         cnt <= state == IO_WAIT ? cnt + 1'b1 : '0;
         if (state == IDLE && bus.cpu_req) begin
            we_q    <= bus.cpu_we;
            addr_q  <= bus.cpu_addr;
            wdata_q <= bus.cpu_wdata;
            be_q    <= bus.cpu_be;
            k_q     <= kw[KW-1:0];
            off_q   <= off & OFF_MASK;
            err_q   <= bad;
            if (bad) rdata_q <= '0;
         end
         if (state == MEM_RD) rdata_q <= bus.m_rdata;
         // An ack in the expiry cycle still counts as a successful completion.
         if (state == IO_WAIT && ack) begin
            err_q <= 1'b0;
            if (!we_q) rdata_q <= bus.io_rdata[k_q*DATA_W +: DATA_W];
         end else if (state == IO_WAIT && tmo) begin
            err_q   <= 1'b1;
            rdata_q <= '0;
         end
      end
   assign bus.cpu_ready = state == RESP;
   assign bus.cpu_err   = state == RESP && err_q;
   assign bus.cpu_rdata = rdata_q;
   assign bus.m_en      = state == MEM;
   assign bus.m_we      = state == MEM && we_q;
   assign bus.m_addr    = addr_q;
   assign bus.m_wdata   = wdata_q;
   assign bus.m_be      = be_q;
   assign bus.io_sel    = state == IO_WAIT ? N_IO'(1) << k_q : '0;
   assign bus.io_we     = we_q;
   assign bus.io_addr   = off_q;
   assign bus.io_wdata  = wdata_q;
   assign bus.io_be     = be_q;
endmodule

// File: tb/tb_mem_io_router.sv
// tb_mem_io_router: directed vector table plus reset-abort sequence for mem_io_router.
module tb_mem_io_router;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_chk = 0;
   int   n_fail = 0;
   mem_io_router_if bus ();
   mem_io_router dut (.clk(clk), .rst(rst), .bus(bus));
   always #5 clk = ~clk;
   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  be;
      logic [31:0] mdat;
      int          ch;
      int          ack;
      logic [3:0]  noise;
      logic [31:0] iod;
      logic        pulse;
      int          lat;
      logic        err;
      logic [31:0] rd;
      int          men;
      logic [3:0]  sel;
      logic [31:0] ioa;
   } vec_t;
   function automatic vec_t mk(logic we, logic [31:0] addr, logic [31:0] wdata, logic [3:0] be,
                               logic [31:0] mdat, int ch, int ack, logic [3:0] noise,
                               logic [31:0] iod, logic pulse, int lat, logic err,
                               logic [31:0] rd, int men, logic [3:0] sel, logic [31:0] ioa);
      vec_t v;
      v.we = we; v.addr = addr; v.wdata = wdata; v.be = be; v.mdat = mdat;
      v.ch = ch; v.ack = ack; v.noise = noise; v.iod = iod; v.pulse = pulse;
      v.lat = lat; v.err = err; v.rd = rd; v.men = men; v.sel = sel; v.ioa = ioa;
      return v;
   endfunction
   function automatic logic [127:0] fill(int ch, logic [31:0] d);
      logic [127:0] r;
      for (int k = 0; k < 4; k++) r[k*32 +: 32] = k == ch ? d : 32'hBAD0_0000 | 32'(k);
      return r;
   endfunction
   task automatic chk(int id, string what, logic [31:0] act, logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL vec%0d %s: got %0h, expected %0h", id, what, act, exp);
      end
   endtask
   task automatic run(int id, vec_t v);
      int          lat = 0;
      int          men = 0;
      int          w = 0;
      logic [3:0]  sel = '0;
      logic [3:0]  mbe = '0;
      logic [31:0] ioa = '0;
      logic [31:0] wd = '0;
      logic [31:0] rd = '0;
      logic        iowe = 1'b0;
      logic        mwe = 1'b0;
      logic        err = 1'b0;
      logic        excl = 1'b1;
      logic        prev_men = 1'b0;
      bus.cpu_req = 1'b1;
      bus.cpu_we = v.we;
      bus.cpu_addr = v.addr;
      bus.cpu_wdata = v.wdata;
      bus.cpu_be = v.be;
      bus.io_ack = v.noise;
      bus.io_rdata = fill(v.ch, v.iod);
      for (int n = 1; n <= 40 && lat == 0; n++) begin
         @(negedge clk);
         bus.m_rdata = prev_men ? v.mdat : '0;
         bus.io_ack = v.noise;
         if (v.pulse) bus.cpu_req = 1'b0;
         if (bus.m_en) begin
            men++;
            mwe = bus.m_we;
            mbe = bus.m_be;
            wd = bus.m_wdata;
         end
         prev_men = bus.m_en;
         if (bus.io_sel != '0) begin
            w++;
            sel |= bus.io_sel;
            ioa = bus.io_addr;
            iowe = bus.io_we;
            wd = bus.io_wdata;
            if (w == v.ack) bus.io_ack = v.noise | (4'b0001 << v.ch);
         end
         if ((bus.m_en && bus.io_sel != '0) || $countones(bus.io_sel) > 1) excl = 1'b0;
         if (bus.cpu_ready) begin
            lat = n;
            err = bus.cpu_err;
            rd = bus.cpu_rdata;
            bus.cpu_req = 1'b0;
         end
      end
      @(negedge clk);
      bus.io_ack = '0;
      bus.m_rdata = '0;
      chk(id, "latency", 32'(lat), 32'(v.lat));
      chk(id, "ready_pulse", 32'(bus.cpu_ready), 32'd0);
      chk(id, "err", 32'(err), 32'(v.err));
      chk(id, "rdata", rd, v.rd);
      chk(id, "m_en_cycles", 32'(men), 32'(v.men));
      chk(id, "m_we", 32'(mwe), 32'(v.men != 0 && v.we));
      chk(id, "m_be", 32'(mbe), v.men != 0 ? 32'(v.be) : 32'd0);
      chk(id, "io_sel", 32'(sel), 32'(v.sel));
      chk(id, "io_addr", ioa, v.ioa);
      chk(id, "io_we", 32'(iowe), 32'(v.sel != '0 && v.we));
      chk(id, "wdata", wd, (v.men != 0 || v.sel != '0) ? v.wdata : 32'd0);
      chk(id, "exclusive", 32'(excl), 32'd1);
   endtask
   initial begin
      vec_t vt[16];
      logic rdy;
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end
   initial begin
      vec_t vt[16];
      logic rdy;
      bus.cpu_req = 1'b0;
      bus.cpu_we = 1'b0;
      bus.cpu_addr = '0;
      bus.cpu_wdata = '0;
      bus.cpu_be = '0;
      bus.m_rdata = '0;
      bus.io_rdata = '0;
      bus.io_ack = '0;
      //            we addr          wdata         be       mdat          ch ack noise    iod           p  lat err rd            men sel      ioa
      vt[0]  = mk(0, 32'h0000_0100, 32'h0,        4'hF,    32'hDEAD_BEEF, 0, 0, 4'b0000, 32'h0,        0, 3,  0, 32'hDEAD_BEEF, 1, 4'b0000, 32'h0);
      vt[1]  = mk(1, 32'h0000_0040, 32'h1234_5678, 4'b0011, 32'h5555_5555, 0, 0, 4'b0000, 32'h0,        0, 2,  0, 32'hDEAD_BEEF, 1, 4'b0000, 32'h0);
      vt[2]  = mk(0, 32'hFFFF_FC24, 32'h0,        4'hF,    32'h0,         2, 5, 4'b0000, 32'h0000_00AB, 1, 6,  0, 32'h0000_00AB, 0, 4'b0100, 32'h4);
      vt[3]  = mk(1, 32'hFFFF_FC38, 32'hA5A5_5A5A, 4'b1100, 32'h0,         3, 1, 4'b0000, 32'h0000_1111, 0, 2,  0, 32'h0000_00AB, 0, 4'b1000, 32'h8);
      vt[4]  = mk(0, 32'hFFFF_FC10, 32'h0,        4'hF,    32'h0,         1, 0, 4'b1101, 32'h0000_2222, 0, 17, 1, 32'h0,         0, 4'b0010, 32'h0);
      vt[5]  = mk(0, 32'h0000_FFFC, 32'h0,        4'hF,    32'hCAFE_F00D, 0, 0, 4'b0000, 32'h0,        0, 3,  0, 32'hCAFE_F00D, 1, 4'b0000, 32'h0);
      vt[6]  = mk(0, 32'h0001_0000, 32'h0,        4'hF,    32'h0,         0, 0, 4'b0000, 32'h0,        0, 1,  1, 32'h0,         0, 4'b0000, 32'h0);
      vt[7]  = mk(0, 32'h0000_0000, 32'h0,        4'hF,    32'h0000_0011, 0, 0, 4'b0000, 32'h0,        0, 3,  0, 32'h0000_0011, 1, 4'b0000, 32'h0);
      vt[8]  = mk(0, 32'hFFFF_FC40, 32'h0,        4'hF,    32'h0,         0, 0, 4'b0000, 32'h0,        0, 1,  1, 32'h0,         0, 4'b0000, 32'h0);
      vt[9]  = mk(0, 32'hFFFF_FC00, 32'h0,        4'hF,    32'h0,         0, 2, 4'b1110, 32'h0000_0055, 0, 3,  0, 32'h0000_0055, 0, 4'b0001, 32'h0);
      vt[10] = mk(1, 32'h0000_0002, 32'h0,        4'hF,    32'h0,         0, 0, 4'b0000, 32'h0,        0, 1,  1, 32'h0,         0, 4'b0000, 32'h0);
      vt[11] = mk(0, 32'hFFFF_FC0C, 32'h0,        4'hF,    32'h0,         0, 16, 4'b0000, 32'h0000_0077, 0, 17, 0, 32'h0000_0077, 0, 4'b0001, 32'hC);
      vt[12] = mk(0, 32'hFFFF_FBFC, 32'h0,        4'hF,    32'h0,         0, 0, 4'b0000, 32'h0,        0, 1,  1, 32'h0,         0, 4'b0000, 32'h0);
      vt[13] = mk(0, 32'hFFFF_FC22, 32'h0,        4'hF,    32'h0,         2, 1, 4'b0000, 32'h0000_3333, 0, 1,  1, 32'h0,         0, 4'b0000, 32'h0);
      vt[14] = mk(0, 32'hFFFF_FC3C, 32'h0,        4'hF,    32'h0,         3, 1, 4'b0000, 32'h0000_0099, 0, 2,  0, 32'h0000_0099, 0, 4'b1000, 32'hC);
      vt[15] = mk(0, 32'h0000_0200, 32'h0,        4'hF,    32'h1357_9BDF, 0, 0, 4'b0000, 32'h0,        0, 3,  0, 32'h1357_9BDF, 1, 4'b0000, 32'h0);
      repeat (2) @(negedge clk);
      chk(-1, "rst_ready", 32'(bus.cpu_ready), 32'd0);
      chk(-1, "rst_err", 32'(bus.cpu_err), 32'd0);
      chk(-1, "rst_rdata", bus.cpu_rdata, 32'd0);
      chk(-1, "rst_m_en", 32'(bus.m_en), 32'd0);
      chk(-1, "rst_io_sel", 32'(bus.io_sel), 32'd0);
      rst = 1'b0;
      @(negedge clk);
      for (int i = 0; i < 15; i++) run(i, vt[i]);
      bus.cpu_req = 1'b1;
      bus.cpu_we = 1'b0;
      bus.cpu_addr = 32'hFFFF_FC28;
      bus.io_rdata = fill(2, 32'h0000_1234);
      repeat (3) @(negedge clk);
      chk(90, "sel_before_rst", 32'(bus.io_sel), 32'h4);
      bus.cpu_req = 1'b0;
      rst = 1'b1;
      #1;
      chk(90, "sel_async_rst", 32'(bus.io_sel), 32'd0);
      chk(90, "rdata_async_rst", bus.cpu_rdata, 32'd0);
      chk(90, "io_addr_async_rst", bus.io_addr, 32'd0);
      chk(90, "m_addr_async_rst", bus.m_addr, 32'd0);
      rdy = 1'b0;
      repeat (3) begin
         @(negedge clk);
         rdy |= bus.cpu_ready;
      end
      chk(90, "no_ready_in_rst", 32'(rdy), 32'd0);
      rst = 1'b0;
      @(negedge clk);
      run(15, vt[15]);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/mem_io_router.md
Name: mem_io_router

Overview:
- Parametrised, sequential successor to the single-cycle memory/IO address decoder.
- Sits between the CPU load/store stage and two targets: data memory (synchronous BRAM, 1-cycle read latency) and N_IO peripheral channels.
- Peripheral channels answer with an acknowledge handshake.
- Adds a request/ready handshake, byte enables, per-channel IO select, timeout and error reporting for unmapped or misaligned accesses.

Parameters:
- DATA_W, 32, data bus width
- ADDR_W, 32, address width
- MEM_LOW, 32'h0000_0000, lowest data-memory address (inclusive)
- MEM_HIGH, 32'h0000_FFFF, highest data-memory address (inclusive)
- N_IO, 4, number of peripheral channels (1..16)
- IO_BASE, 32'hFFFF_FC00, base address of channel 0
- IO_STRIDE, 16, bytes per channel window (power of two)
- TIMEOUT, 16, max cycles to wait for io_ack (>=2)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- cpu_req  in  1  access request; held with all cpu_* inputs until cpu_ready
- cpu_we  in  1  1 = store, 0 = load
- cpu_addr  in  ADDR_W  byte address
- cpu_wdata  in  DATA_W  store data
- cpu_be  in  DATA_W/8  byte enables
- cpu_ready  out  1  one-cycle completion pulse
- cpu_rdata  out  DATA_W  load data, valid with cpu_ready, held until next completion
- cpu_err  out  1  completion carries an error; valid with cpu_ready
- m_en  out  1  memory access strobe
- m_we  out  1  memory write
- m_addr  out  ADDR_W  memory address
- m_wdata  out  DATA_W  memory write data
- m_be  out  DATA_W/8  memory byte enables
- m_rdata  in  DATA_W  memory read data, valid one cycle after m_en
- io_sel  out  N_IO  one-hot channel select
- io_we  out  1  IO write
- io_addr  out  ADDR_W  offset within the channel window
- io_wdata  out  DATA_W  IO write data
- io_be  out  DATA_W/8  IO byte enables
- io_rdata  in  N_IO*DATA_W  flattened read data; channel k occupies bits [k*DATA_W +: DATA_W]
- io_ack  in  N_IO  per-channel completion

Behaviour:
- Reset (async, any time): state=IDLE, timeout counter=0. All outputs 0 (cpu_ready, cpu_rdata, cpu_err, m_*, io_*).
  - An in-flight transaction is aborted: no cpu_ready, io_sel drops immediately.
- Decode, evaluated in IDLE:
  - mem_hit = MEM_LOW <= addr <= MEM_HIGH.
  - k = (addr - IO_BASE) / IO_STRIDE; io_hit = addr >= IO_BASE and k < N_IO.
  - mem_hit takes priority if the ranges overlap.
  - misaligned = addr[1:0] != 0.
- FSM states: IDLE, MEM, MEM_RD, IO_WAIT, RESP.
  - IDLE: on cpu_req, latch addr/we/wdata/be/k.
    - misaligned or no hit -> RESP with err=1.
    - mem_hit -> MEM.
    - io_hit -> IO_WAIT.
  - MEM: m_en=1 for exactly this cycle, with m_we/m_addr/m_wdata/m_be from the latches. Store -> RESP; load -> MEM_RD.
  - MEM_RD: capture m_rdata into the rdata register -> RESP.
  - IO_WAIT: io_sel[k]=1 and io_we/io_addr (addr - IO_BASE - k*IO_STRIDE)/io_wdata/io_be held stable. Counter increments each cycle.
    - io_ack[k]=1 -> capture io_rdata slice k (loads only), err=0, -> RESP. io_sel drops the same edge.
    - Counter reaches TIMEOUT-1 without ack -> RESP with err=1, rdata=0.
    - io_ack bits of other channels are ignored.
  - RESP: cpu_ready=1 for one cycle, cpu_err per result -> IDLE. The counter clears.
- Latency from the cpu_req sample edge to cpu_ready high:
  - memory store: 2 cycles
  - memory load: 3 cycles
  - error: 1 cycle
  - IO: (ack cycle + 1)
- Back-to-back: a new request is sampled in the IDLE cycle after RESP. Minimum issue interval = latency + 1.
- Outputs are registered/state-decoded; none is combinational from cpu_* inputs.
- cpu_rdata updates only on successful loads. Stores and errors leave it 0 (error) or unchanged (store).
- If cpu_req drops mid-transaction, the transaction still completes and cpu_ready still pulses.
- io_ack arriving in the same cycle as timeout expiry: ack wins, err=0.
- m_en and io_sel are never high simultaneously. At most one io_sel bit is ever set.

Test Plan:
- Load at 32'h0000_0100, memory returns 32'hDEAD_BEEF -> m_en pulses one cycle; cpu_ready 3 cycles after sample; cpu_rdata=32'hDEAD_BEEF, cpu_err=0.
- Store 32'h1234_5678, be=4'b0011, to 32'h0000_0040 -> m_en=m_we=1 one cycle with m_be=4'b0011; cpu_ready 2 cycles after sample; io_sel stays 0.
- Load at 32'hFFFF_FC24 (channel 2, offset 4), ack after 5 cycles with slice 2 = 32'h0000_00AB -> io_sel=4'b0100, io_addr=4; cpu_rdata=32'hAB, err=0.
- IO load to channel 1, never acked -> cpu_ready with cpu_err=1, rdata=0 after TIMEOUT=16 wait cycles; io_sel clears.
- Accesses to 32'h0001_0000 (unmapped), 32'hFFFF_FC40 (k=4 >= N_IO) and 32'h0000_0002 (misaligned) -> each gives cpu_ready 1 cycle after sample with err=1, no m_en, no io_sel.
- rst asserted during IO_WAIT -> io_sel and all outputs 0 immediately; no cpu_ready; a new request after reset is served normally.
